lou_arbiter: RTL and testbench

Shares one logical operations unit (LOU: NAND/NOR/XNOR/compare, 4-bit operands, 8-bit result) between two requesters. Each request is accepted with a valid/ready handshake and granted round-robin. The arbiter drives the LOU inputs from registered operands for a programmable settle time, captures the 8-bit result, and returns it on a single response channel tagged with the requester ID. It sits between the instruction front end and the LOU instance, and is the only driver of the LOU inputs.

---
 rtl/lou_arbiter.sv | 142 ++++++++++++++
 tb/tb_lou_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lou_arbiter.sv
// Round-robin arbiter sharing one logical operations unit between two requesters.
// One operation in flight: accept, hold LOU inputs for EXEC_CYCLES, capture, respond.
module lou_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter logic [3:0]  OP_MAX      = 4'h5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_y,
    output logic       rsp_err,
    output logic [3:0] lou_op_code,
    output logic [3:0] lou_a,
    output logic [3:0] lou_b,
    input  logic [7:0] lou_y
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state_q;
    logic       last_grant_q;
    logic       id_q;
    logic       rsp_valid_q;
    logic       rsp_err_q;
    logic [7:0] rsp_y_q;
    logic [3:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] cnt_q;

    logic       winner_d;
    logic [1:0] grant_d;
    logic       accept_d;
    logic [3:0] sel_op_d;
    logic [3:0] sel_a_d;
    logic [3:0] sel_b_d;

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        winner_d = 1'b0;
        case (req_valid)
            2'b01:   winner_d = 1'b0;
            2'b10:   winner_d = 1'b1;
            2'b11:   winner_d = ~last_grant_q;
            default: winner_d = 1'b0;
        endcase

        grant_d = 2'b00;
        if ((state_q == ST_IDLE) && !reset && (req_valid != 2'b00)) begin
            grant_d = winner_d ? 2'b10 : 2'b01;
        end
        accept_d = |(grant_d & req_valid);

        sel_op_d = winner_d ? req1_op : req0_op;
        sel_a_d  = winner_d ? req1_a  : req0_a;
        sel_b_d  = winner_d ? req1_b  : req0_b;
    end

    // Operand registers double as the LOU drivers; they are cleared on the
    // way back to IDLE so the LOU sees zeros whenever nothing is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_y_q      <= 8'h00;
            op_q         <= 4'h0;
            a_q          <= 4'h0;
            b_q          <= 4'h0;
            cnt_q        <= 4'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        op_q         <= sel_op_d;
                        a_q          <= sel_a_d;
                        b_q          <= sel_b_d;
                        id_q         <= winner_d;
                        last_grant_q <= winner_d;
                        cnt_q        <= CNT_INIT;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 4'h0) begin
                        rsp_valid_q <= 1'b1;
                        if (op_q <= OP_MAX) begin
                            rsp_y_q   <= lou_y;
                            rsp_err_q <= 1'b0;
                        end else begin
                            rsp_y_q   <= 8'h00;
                            rsp_err_q <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'h1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_q        <= 4'h0;
                        a_q         <= 4'h0;
                        b_q         <= 4'h0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = grant_d;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_y       = rsp_y_q;
    assign rsp_err     = rsp_err_q;
    assign lou_op_code = op_q;
    assign lou_a       = a_q;
    assign lou_b       = b_q;

endmodule

// File: tb/tb_lou_arbiter.sv
// Self-checking bench for lou_arbiter with a LOU stub y = {op, a ^ b}.
// Two instances: default EXEC_CYCLES=1 and EXEC_CYCLES=4, sharing stimulus.
module tb_lou_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic       rsp_ready;
    logic [3:0] op0, a0, b0, op1, a1, b1;

    logic [1:0] req_ready, req_ready4;
    logic       rsp_valid, rsp_valid4;
    logic       rsp_id, rsp_id4;
    logic [7:0] rsp_y, rsp_y4;
    logic       rsp_err, rsp_err4;
    logic [3:0] lou_op, lou_a, lou_b, lou_op4, lou_a4, lou_b4;
    logic [7:0] lou_y, lou_y4;

    int   n_chk;
    int   n_fail;
    logic last_m;

    assign lou_y  = {lou_op, lou_a ^ lou_b};
    assign lou_y4 = {lou_op4, lou_a4 ^ lou_b4};

    lou_arbiter dut (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_err(rsp_err),
        .lou_op_code(lou_op), .lou_a(lou_a), .lou_b(lou_b), .lou_y(lou_y)
    );

    lou_arbiter #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready4),
        .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4),
        .rsp_y(rsp_y4), .rsp_err(rsp_err4),
        .lou_op_code(lou_op4), .lou_a(lou_a4), .lou_b(lou_b4), .lou_y(lou_y4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result of one operation straight from the operation rules.
    function automatic logic [7:0] ref_y(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        return (op > 4'h5) ? 8'h00 : {op, a ^ b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        req_valid = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_m = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 2'b00; rsp_ready = 1'b0;
        op0 = 0; a0 = 0; b0 = 0; op1 = 0; a1 = 0; b1 = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_chk++; if ({req_ready, rsp_valid, rsp_id, rsp_y, rsp_err, lou_op, lou_a, lou_b} !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", {req_ready, rsp_valid, rsp_id, rsp_y, rsp_err, lou_op, lou_a, lou_b}); end
        n_chk++; if ({req_ready4, rsp_valid4, rsp_id4, rsp_y4, rsp_err4, lou_op4, lou_a4, lou_b4} !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs4 got=%h exp=0", {req_ready4, rsp_valid4, rsp_id4, rsp_y4, rsp_err4, lou_op4, lou_a4, lou_b4}); end
        req_valid = 2'b11;
        #1;
        n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        step();
        req_valid = 2'b00;
        step();
        rst = 1'b0;
        last_m = 1'b1;
        smp();
        n_chk++; if ({req_ready, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_idle got=%b exp=000", {req_ready, rsp_valid}); end
        step();
    endtask

    task automatic test_single();
        req_valid = 2'b01; op0 = 4'h0; a0 = 4'hA; b0 = 4'h9; rsp_ready = 1'b1;
        smp();
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant got=%b exp=01", req_ready); end
        step(); req_valid = 2'b00;
        smp();
        n_chk++; if ({lou_op, lou_a, lou_b} !== 12'h0A9) begin n_fail++; $display("FAIL single_lou got=%h exp=0a9", {lou_op, lou_a, lou_b}); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp got=%b exp=0", rsp_valid); end
        step();
        smp();
        n_chk++; if ({rsp_valid, rsp_y, rsp_id, rsp_err} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL single_rsp got v=%b y=%h id=%b err=%b exp v=1 y=03 id=0 err=0", rsp_valid, rsp_y, rsp_id, rsp_err); end
        step();
        smp();
        n_chk++; if ({rsp_valid, lou_op, lou_a, lou_b} !== 13'd0) begin
            n_fail++; $display("FAIL single_back_idle got v=%b lou=%h exp v=0 lou=000", rsp_valid, {lou_op, lou_a, lou_b}); end
        last_m = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int gid[$];
        int gcyc[$];
        int rid[$];
        logic [7:0] ry[$];
        reset_pulse();
        req_valid = 2'b11; rsp_ready = 1'b1;
        op0 = 4'h1; a0 = 4'h6; b0 = 4'h3;
        op1 = 4'h2; a1 = 4'hC; b1 = 4'hA;
        for (int c = 0; c < 12; c++) begin
            smp();
            if (req_ready == 2'b01) begin gid.push_back(0); gcyc.push_back(c); end
            else if (req_ready == 2'b10) begin gid.push_back(1); gcyc.push_back(c); end
            else if (req_ready != 2'b00) begin gid.push_back(2); gcyc.push_back(c); end
            if (rsp_valid) begin rid.push_back(int'(rsp_id)); ry.push_back(rsp_y); end
            step();
        end
        req_valid = 2'b00;
        n_chk++; if (gid.size() !== 4) begin n_fail++; $display("FAIL rr_grant_count got=%0d exp=4", gid.size()); end
        n_chk++; if (rid.size() !== 4) begin n_fail++; $display("FAIL rr_rsp_count got=%0d exp=4", rid.size()); end
        for (int i = 0; i < gid.size() && i < 4; i++) begin
            n_chk++; if (gid[i] !== (i % 2)) begin n_fail++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, gid[i], i % 2); end
            if (i > 0) begin
                n_chk++; if (gcyc[i] - gcyc[i-1] !== 3) begin n_fail++; $display("FAIL rr_spacing idx=%0d got=%0d exp=3", i, gcyc[i] - gcyc[i-1]); end
            end
        end
        for (int i = 0; i < rid.size() && i < 4; i++) begin
            n_chk++; if (rid[i] !== (i % 2)) begin n_fail++; $display("FAIL rr_rsp_id idx=%0d got=%0d exp=%0d", i, rid[i], i % 2); end
            n_chk++; if (ry[i] !== ((i % 2 == 0) ? ref_y(op0, a0, b0) : ref_y(op1, a1, b1))) begin
                n_fail++; $display("FAIL rr_rsp_y idx=%0d got=%h", i, ry[i]); end
        end
        last_m = 1'b1;
    endtask

    task automatic test_illegal();
        logic [3:0] ops [4];
        ops[0] = 4'h7; ops[1] = 4'h5; ops[2] = 4'h6; ops[3] = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 2'b10; op1 = ops[i]; a1 = 4'hF; b1 = 4'h0;
            smp();
            n_chk++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL illegal_grant op=%h got=%b exp=10", ops[i], req_ready); end
            step(); req_valid = 2'b00;
            smp();
            n_chk++; if ({rsp_valid, lou_op, lou_a, lou_b} !== {1'b0, ops[i], 4'hF, 4'h0}) begin
                n_fail++; $display("FAIL illegal_exec op=%h got v=%b lou=%h", ops[i], rsp_valid, {lou_op, lou_a, lou_b}); end
            step();
            smp();
            n_chk++; if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, 1'b1, ref_y(ops[i], 4'hF, 4'h0), ops[i] > 4'h5}) begin
                n_fail++; $display("FAIL illegal_rsp op=%h got v=%b id=%b y=%h err=%b exp y=%h err=%b",
                                   ops[i], rsp_valid, rsp_id, rsp_y, rsp_err, ref_y(ops[i], 4'hF, 4'h0), ops[i] > 4'h5); end
            step();
        end
        last_m = 1'b1;
    endtask

    task automatic test_backpressure();
        req_valid = 2'b01; op0 = 4'h4; a0 = 4'h3; b0 = 4'hC; rsp_ready = 1'b0;
        smp();
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant got=%b exp=01", req_ready); end
        step();
        smp();
        n_chk++; if ({req_ready, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL bp_exec got=%b exp=000", {req_ready, rsp_valid}); end
        step();
        for (int s = 0; s < 5; s++) begin
            smp();
            n_chk++; if ({rsp_valid, rsp_y, req_ready} !== {1'b1, 8'h4F, 2'b00}) begin
                n_fail++; $display("FAIL bp_stall cyc=%0d got v=%b y=%h rdy=%b exp v=1 y=4f rdy=00", s, rsp_valid, rsp_y, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        smp();
        n_chk++; if ({rsp_valid, req_ready} !== 3'b100) begin n_fail++; $display("FAIL bp_release got=%b exp=100", {rsp_valid, req_ready}); end
        step();
        smp();
        n_chk++; if ({req_ready, rsp_valid} !== 3'b010) begin n_fail++; $display("FAIL bp_regrant got=%b exp=010", {req_ready, rsp_valid}); end
        step(); req_valid = 2'b00;
        step();
        smp();
        n_chk++; if ({rsp_valid, rsp_y} !== {1'b1, 8'h4F}) begin n_fail++; $display("FAIL bp_second_rsp got v=%b y=%h exp v=1 y=4f", rsp_valid, rsp_y); end
        step();
        last_m = 1'b0;
    endtask

    task automatic test_exec4();
        reset_pulse();
        req_valid = 2'b01; op0 = 4'h3; a0 = 4'h5; b0 = 4'h3; rsp_ready = 1'b1;
        smp();
        n_chk++; if (req_ready4 !== 2'b01) begin n_fail++; $display("FAIL ex4_grant got=%b exp=01", req_ready4); end
        step(); req_valid = 2'b00;
        for (int s = 1; s <= 4; s++) begin
            smp();
            n_chk++; if ({rsp_valid4, lou_op4, lou_a4, lou_b4} !== 13'h0353) begin
                n_fail++; $display("FAIL ex4_hold cyc=%0d got v=%b lou=%h exp v=0 lou=353", s, rsp_valid4, {lou_op4, lou_a4, lou_b4}); end
            step();
        end
        smp();
        n_chk++; if ({rsp_valid4, rsp_y4, rsp_err4} !== {1'b1, 8'h36, 1'b0}) begin
            n_fail++; $display("FAIL ex4_rsp got v=%b y=%h err=%b exp v=1 y=36 err=0", rsp_valid4, rsp_y4, rsp_err4); end
        step();
        smp();
        n_chk++; if (rsp_valid4 !== 1'b0) begin n_fail++; $display("FAIL ex4_idle got=%b exp=0", rsp_valid4); end
        step();
        last_m = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        req_valid = 2'b01; op0 = 4'h2; a0 = 4'h5; b0 = 4'h6; rsp_ready = 1'b1;
        step(); req_valid = 2'b00;
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({req_ready, rsp_valid, rsp_id, rsp_y, rsp_err, lou_op, lou_a, lou_b} !== 27'd0) begin
            n_fail++; $display("FAIL midrst_outputs got=%h exp=0", {req_ready, rsp_valid, rsp_id, rsp_y, rsp_err, lou_op, lou_a, lou_b}); end
        step();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            smp();
            n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost_rsp cyc=%0d got=%b exp=0", s, rsp_valid); end
            step();
        end
        req_valid = 2'b11; op1 = 4'h1; a1 = 4'h1; b1 = 4'h2;
        smp();
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_tie got=%b exp=01", req_ready); end
        step(); req_valid = 2'b00;
        step(); step();
        last_m = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] v;
        logic       w;
        logic [3:0] eo, ea, eb;
        int         idle_n;
        int         stall;
        rsp_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            idle_n = $urandom_range(0, 2);
            for (int s = 0; s < idle_n; s++) begin
                req_valid = 2'b00;
                smp();
                n_chk++; if ({req_ready, rsp_valid, lou_op, lou_a, lou_b} !== 15'd0) begin
                    n_fail++; $display("FAIL rnd_idle t=%0d got=%h exp=0", t, {req_ready, rsp_valid, lou_op, lou_a, lou_b}); end
                step();
            end
            v = 2'($urandom_range(1, 3));
            op0 = 4'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
            op1 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            stall = $urandom_range(0, 3);
            w  = (v == 2'b11) ? ~last_m : v[1];
            eo = w ? op1 : op0; ea = w ? a1 : a0; eb = w ? b1 : b0;
            req_valid = v;
            smp();
            n_chk++; if (req_ready !== (w ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL rnd_grant t=%0d valid=%b got=%b exp_winner=%0d", t, v, req_ready, w); end
            step(); req_valid = 2'b00;
            last_m = w;
            smp();
            n_chk++; if ({rsp_valid, req_ready, lou_op, lou_a, lou_b} !== {1'b0, 2'b00, eo, ea, eb}) begin
                n_fail++; $display("FAIL rnd_exec t=%0d got v=%b rdy=%b lou=%h exp lou=%h", t, rsp_valid, req_ready, {lou_op, lou_a, lou_b}, {eo, ea, eb}); end
            step();
            rsp_ready = (stall == 0);
            for (int s = 0; s <= stall; s++) begin
                if (s > 0) begin step(); rsp_ready = (s == stall); req_valid = 2'($urandom_range(0, 3)); end
                smp();
                n_chk++; if ({rsp_valid, rsp_id, rsp_y, rsp_err, req_ready} !== {1'b1, w, ref_y(eo, ea, eb), eo > 4'h5, 2'b00}) begin
                    n_fail++; $display("FAIL rnd_rsp t=%0d s=%0d got v=%b id=%b y=%h err=%b rdy=%b exp id=%b y=%h err=%b",
                                       t, s, rsp_valid, rsp_id, rsp_y, rsp_err, req_ready, w, ref_y(eo, ea, eb), eo > 4'h5); end
            end
            step();
            req_valid = 2'b00;
            rsp_ready = 1'b1;
            smp();
            n_chk++; if ({rsp_valid, lou_op, lou_a, lou_b} !== 13'd0) begin
                n_fail++; $display("FAIL rnd_back_idle t=%0d got=%h exp=0", t, {rsp_valid, lou_op, lou_a, lou_b}); end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        last_m = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_illegal();
        test_backpressure();
        test_exec4();
        test_reset_mid_exec();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
